t_sync_counter: RTL and testbench

Synchronous modulo-N up/down counter built from a row of toggle cells: combinational logic computes each bit's T input from the current count and the control inputs, and the cells toggle on the rising clock edge. It drives the toggle-cell stage and replaces hand-wired ripple chains wherever the design needs a divide-by-N, a BCD digit or a loadable event counter. A terminal-count output allows digits to be cascaded.

---
 rtl/t_pkg.sv | 11 +
 rtl/tff_cell.sv | 18 +
 rtl/t_sync_counter.sv | 78 +++++++
 tb/tb_t_sync_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t_pkg.sv
// Shared constants for the toggle-cell counter family.
// Defaults describe a single BCD digit.
package t_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int BCD_WIDTH  = 4;
  localparam int BCD_MODULO = 10;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: flips its state on a rising edge whenever T is high.
// Asynchronous active-low reset clears it to 0.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/t_sync_counter.sv
// Synchronous modulo-N up/down counter built from a row of toggle cells.
// The next-state logic resolves clr > load > en > hold and drives each cell's T input.
module t_sync_counter
  import t_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int MODULO = BCD_MODULO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  generate
    if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
      $error("t_sync_counter: MODULO must lie in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t_vec;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (Q == MAX_Q);
  assign at_zero = (Q == '0);

  // Wrap points are compared explicitly so a full-range MODULO never leans on overflow.
  always_comb begin
    next_q = Q;
    if (clr) begin
      next_q = '0;
    end else if (load) begin
      next_q = ({1'b0, din} < MOD_EXT) ? din : MAX_Q;
    end else if (en) begin
      if (up == DIR_UP) begin
        next_q = at_max ? '0 : Q + WIDTH'(1);
      end else begin
        next_q = at_zero ? MAX_Q : Q - WIDTH'(1);
      end
    end
  end

  assign t_vec = Q ^ next_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .T   (t_vec[i]),
        .Q   (Q[i])
      );
    end
  endgenerate

  assign tc = rst & en & ~clr & ~load &
              (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_t_sync_counter.sv
// Self-checking bench for t_sync_counter: directed table, corner-case sequences,
// a two-digit cascade and randomized traffic against a modular-arithmetic model.
module tb_t_sync_counter;
  import t_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up;
  logic [3:0] din;
  logic [3:0] q10, q16;
  logic       tc10, tc16, wrap10, wrap16;

  logic       c_clr, c_load, c_en, c_up;
  logic [3:0] c_din;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] din;
    int         exp_tc;
    int         exp_q;
    int         exp_wrap;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  t_sync_counter #(.WIDTH(4), .MODULO(10)) dut10 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .Q(q10), .tc(tc10), .wrap(wrap10)
  );

  t_sync_counter #(.WIDTH(4), .MODULO(16)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .Q(q16), .tc(tc16), .wrap(wrap16)
  );

  t_sync_counter #(.WIDTH(4), .MODULO(10)) u_lo (
    .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .din(c_din), .en(c_en), .up(c_up),
    .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );

  t_sync_counter #(.WIDTH(4), .MODULO(10)) u_hi (
    .clk(clk), .rst(rst), .clr(c_clr), .load(c_load), .din(c_din), .en(lo_tc), .up(c_up),
    .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic l, input logic e,
                               input logic u, input logic [3:0] d);
    clr  = c;
    load = l;
    en   = e;
    up   = u;
    din  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour expressed as plain modular arithmetic.
  function automatic int modelNext(input int q, input int modv, input logic c, input logic l,
                                   input logic e, input logic u, input int d);
    if (c) return 0;
    if (l) return (d < modv) ? d : modv - 1;
    if (e) return u ? (q + 1) % modv : (q + modv - 1) % modv;
    return q;
  endfunction

  function automatic int modelTc(input int q, input int modv, input logic c, input logic l,
                                 input logic e, input logic u);
    if (!e || c || l) return 0;
    return (u ? (q == modv - 1) : (q == 0)) ? 1 : 0;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int m10, m16, w10, w16, hi_wraps;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  0, 5, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd13, 0, 9, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  0, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1, 9, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  0, 3, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  0, 9, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd4,  0, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  0, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 0, 9, 0};

    c_clr = 1'b0; c_load = 1'b0; c_en = 1'b0; c_up = DIR_UP; c_din = 4'd0;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, DIR_UP, 4'd0);
    #3;
    checkOutput("reset_q", int'(q10), 0);
    checkOutput("reset_wrap", int'(wrap10), 0);
    checkOutput("reset_tc_gated", int'(tc10), 0);
    tick;
    checkOutput("reset_hold_edge_q", int'(q10), 0);
    rst = 1'b1;
    tick;
    checkOutput("release_first_edge_q", int'(q10), 1);

    // A pending wrap pulse and a non-zero count must both vanish on reset.
    applyStimulus(1'b0, 1'b1, 1'b0, DIR_UP, 4'd9);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b1, DIR_UP, 4'd0);
    tick;
    checkOutput("pre_reset_wrap", int'(wrap10), 1);
    rst = 1'b0;
    #1;
    checkOutput("reset_cancels_wrap", int'(wrap10), 0);
    tick;
    checkOutput("no_toggle_in_reset", int'(q10), 0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, DIR_UP, 4'd7);
    tick;
    checkOutput("load7_q", int'(q10), 7);
    applyStimulus(1'b0, 1'b0, 1'b1, DIR_UP, 4'd0);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_from7_q", int'(q10), 0);
    rst = 1'b1;
    tick;
    checkOutput("resume_after_reset_q", int'(q10), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, DIR_UP, 4'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b1, DIR_UP, 4'd0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("up_run_q%0d", k), int'(q10), k);
      checkOutput($sformatf("up_run_tc%0d", k), int'(tc10), (k == 9) ? 1 : 0);
      tick;
    end
    checkOutput("up_wrap_q", int'(q10), 0);
    checkOutput("up_wrap_pulse", int'(wrap10), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, DIR_UP, 4'd0);
    tick;
    checkOutput("up_wrap_one_cycle", int'(wrap10), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, DIR_UP, 4'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b1, DIR_DOWN, 4'd0);
    #1;
    checkOutput("down_tc_at0", int'(tc10), 1);
    tick;
    checkOutput("down_wrap_q", int'(q10), 9);
    checkOutput("down_wrap_pulse", int'(wrap10), 1);
    tick;
    checkOutput("down_q8", int'(q10), 8);
    checkOutput("down_wrap_cleared", int'(wrap10), 0);
    tick;
    checkOutput("down_q7", int'(q10), 7);

    applyStimulus(1'b0, 1'b1, 1'b0, DIR_UP, 4'd6);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, DIR_UP, 4'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      checkOutput($sformatf("hold_q%0d", k), int'(q10), 6);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, DIR_UP, 4'd0);
    tick;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din);
      #1;
      checkOutput($sformatf("vec%0d_tc", i), int'(tc10), vecs[i].exp_tc);
      tick;
      checkOutput($sformatf("vec%0d_q", i), int'(q10), vecs[i].exp_q);
      checkOutput($sformatf("vec%0d_wrap", i), int'(wrap10), vecs[i].exp_wrap);
    end

    // Two BCD digits chained through tc: 100 edges should roll 00..99 back to 00.
    c_clr = 1'b1;
    tick;
    c_clr = 1'b0;
    c_en  = 1'b1;
    hi_wraps = 0;
    for (int k = 1; k <= 100; k++) begin
      tick;
      checkOutput($sformatf("casc_lo%0d", k), int'(lo_q), k % 10);
      checkOutput($sformatf("casc_hi%0d", k), int'(hi_q), (k / 10) % 10);
      if (hi_wrap) hi_wraps++;
    end
    checkOutput("casc_hi_wrap_count", hi_wraps, 1);
    c_en = 1'b0;
    tick;
    checkOutput("casc_hi_wrap_end", int'(hi_wrap), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, DIR_UP, 4'd0);
    tick;
    m10 = 0; m16 = 0; w10 = 0; w16 = 0;
    for (int i = 0; i < 400; i++) begin
      logic r_clr, r_load, r_en, r_up;
      logic [3:0] r_din;
      int e10, e16;
      r_clr  = ($urandom_range(0, 19) == 0);
      r_load = ($urandom_range(0, 9) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_up   = 1'($urandom_range(0, 1));
      r_din  = 4'($urandom_range(0, 15));
      applyStimulus(r_clr, r_load, r_en, r_up, r_din);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #1;
        checkOutput("rnd_rst_q10", int'(q10), 0);
        checkOutput("rnd_rst_q16", int'(q16), 0);
        checkOutput("rnd_rst_wrap10", int'(wrap10), 0);
        checkOutput("rnd_rst_tc10", int'(tc10), 0);
        tick;
        rst = 1'b1;
        m10 = 0; m16 = 0; w10 = 0; w16 = 0;
        checkOutput("rnd_rst_edge_q10", int'(q10), 0);
      end else begin
        #1;
        e10 = modelTc(m10, 10, r_clr, r_load, r_en, r_up);
        e16 = modelTc(m16, 16, r_clr, r_load, r_en, r_up);
        checkOutput($sformatf("rnd%0d_tc10", i), int'(tc10), e10);
        checkOutput($sformatf("rnd%0d_tc16", i), int'(tc16), e16);
        m10 = modelNext(m10, 10, r_clr, r_load, r_en, r_up, int'(r_din));
        m16 = modelNext(m16, 16, r_clr, r_load, r_en, r_up, int'(r_din));
        w10 = e10;
        w16 = e16;
        tick;
        checkOutput($sformatf("rnd%0d_q10", i), int'(q10), m10);
        checkOutput($sformatf("rnd%0d_q16", i), int'(q16), m16);
        checkOutput($sformatf("rnd%0d_wrap10", i), int'(wrap10), w10);
        checkOutput($sformatf("rnd%0d_wrap16", i), int'(wrap16), w16);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
